path_replayer: RTL
==================

// Module: path_replayer
// PURPOSE
//  Consumer end of the maze solver's move stream: replays each 2-bit move from (0,0) against the maze memory.
//  Certifies that the path stays in range, never enters a wall, and ends on the goal cell.
//  Sits between the solver's move/done outputs and the maze memory's second read port; verdict goes to top-level status.
// PARAMETERS
//  N          4    coordinate width; maze is 2**N x 2**N, memory address = {y,x} (2N bits)
//  GOAL_X     15   goal column
//  GOAL_Y     15   goal row
//  MAX_STEPS  255  moves accepted before overflow error; step counter is 9 bits
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous, active-low reset
//  start      in   1    pulse: clear position/counters, begin replay (ignored unless IDLE/OK/ERR)
//  move_valid in   1    producer has a move on move
//  move       in   2    00 right x+1, 01 up y-1, 10 left x-1, 11 down y+1
//  move_ready out  1    replayer accepts move this cycle (transfer = valid & ready)
//  path_done  in   1    pulse: producer finished sending moves
//  mem_rd     out  1    maze read strobe
//  mem_addr   out  2N   {y_next,x_next}
//  mem_dout   in   1    1 = wall; valid the cycle after mem_rd (1-cycle latency)
//  x_o, y_o   out  N    current replay position
//  steps      out  9    moves accepted since start
//  busy       out  1    replay in progress
//  ok         out  1    path verified (sticky until start)
//  err        out  1    path rejected (sticky until start)
//  err_code   out  2    01 out of range, 10 wall hit, 11 ended off-goal or step overflow
// BEHAVIOUR
//  Reset (rst low, async): state IDLE; x_o=y_o=0, steps=0, move_ready=0, mem_rd=0, busy=ok=err=0, err_code=00.
//  FSM: IDLE -start-> WAIT; WAIT -xfer-> CHECK; CHECK -in range-> READ, else ERR(01);
//       READ (mem_rd=1) -> EVAL; EVAL -mem_dout=1-> ERR(10), else update pos -> WAIT;
//       WAIT -done_pend/path_done & no move-> goal? OK : ERR(11); OK/ERR -start-> WAIT.
//  move_ready=1 only in WAIT; one move per 4 cycles minimum (WAIT,CHECK,READ,EVAL).
//  On transfer: latch move, steps+=1; if steps was MAX_STEPS -> ERR(11) instead of CHECK.
//  Range: next coordinate computed in N+1 bits; borrow below 0 or carry past 2**N-1 is error; no wrap-around.
//  mem_addr driven from the latched next position in READ; held stable in EVAL; 0 elsewhere.
//  Position (x_o,y_o) updates only in EVAL with no wall; a rejected move leaves position at the last legal cell.
//  path_done in WAIT with move_valid high: move transfers first, done_pend flag set, done evaluated on return to WAIT.
//  path_done outside WAIT (CHECK/READ/EVAL) also sets done_pend; done_pend cleared on start.
//  Visiting the goal mid-path is not terminal; only the position at path_done matters.
//  start while busy is ignored; start in OK/ERR clears ok/err/err_code/steps/pos and resumes WAIT next cycle.
//  busy=1 in WAIT..EVAL; ok/err mutually exclusive, stable until next start or reset.
//  Reset mid-replay aborts immediately to IDLE with reset values; no memory read completes.
// TESTING
//  1 start; moves 00x15 then 11x15 on an empty maze, path_done -> ok=1, x_o=y_o=15, steps=30, err=0.
//  2 start; move 10 at (0,0) -> err=1, err_code=01, x_o=y_o=0, mem_rd never asserted.
//  3 wall at {y=0,x=2}; moves 00,00 -> mem_addr=0x02 on 2nd read, err_code=10, x_o=1.
//  4 path_done asserted with move_valid in same cycle, moves reach (15,15) -> move consumed, then ok=1.
//  5 path ends at (3,4) -> err_code=11; then start -> ok=err=0, steps=0, x_o=y_o=0, busy=1.
//  6 256 alternating 00/10 moves -> err_code=11 on 256th transfer; rst low mid-EVAL -> all outputs reset values.

Source files
------------

// File: rtl/path_replayer.sv
// Replays a 2-bit move stream from (0,0) against maze memory and issues an ok/err verdict.
// One move per 4 cycles (WAIT,CHECK,READ,EVAL); move_ready high only while waiting for a move.
module path_replayer #(
   parameter int N         = 4,
   parameter int GOAL_X    = 15,
   parameter int GOAL_Y    = 15,
   parameter int MAX_STEPS = 255
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_start,
   input  logic           i_move_valid,
   input  logic [1:0]     i_move,
   output logic           o_move_ready,
   input  logic           i_path_done,
   output logic           o_mem_rd,
   output logic [2*N-1:0] o_mem_addr,
   input  logic           i_mem_dout,
   output logic [N-1:0]   o_x,
   output logic [N-1:0]   o_y,
   output logic [8:0]     o_steps,
   output logic           o_busy,
   output logic           o_ok,
   output logic           o_err,
   output logic [1:0]     o_err_code
);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CHECK, S_READ, S_EVAL, S_OK, S_ERR} state_t;

   localparam logic [N-1:0] L_GX   = N'(GOAL_X);
   localparam logic [N-1:0] L_GY   = N'(GOAL_Y);
   localparam logic [8:0]   L_MAX  = 9'(MAX_STEPS);
   localparam logic [N:0]   L_ONE  = (N+1)'(1);

   state_t       r_state, w_state_nxt;
   logic [N-1:0] r_x, r_y, r_nx, r_ny, w_x_nxt, w_y_nxt, w_nx_nxt, w_ny_nxt;
   logic [1:0]   r_move, w_move_nxt;
   logic [8:0]   r_steps, w_steps_nxt;
   logic [1:0]   r_code, w_code_nxt;
   logic         r_pend, w_pend_nxt;
   logic [N:0]   w_cx, w_cy;
   logic         w_goal;

   // Extra MSB catches both borrow below 0 and carry past 2**N-1.
   always_comb begin
      w_cx = {1'b0, r_x};
      w_cy = {1'b0, r_y};
      case (r_move)
         2'b00:   w_cx = {1'b0, r_x} + L_ONE;
         2'b01:   w_cy = {1'b0, r_y} - L_ONE;
         2'b10:   w_cx = {1'b0, r_x} - L_ONE;
         default: w_cy = {1'b0, r_y} + L_ONE;
      endcase
   end

   assign w_goal = (r_x == L_GX) && (r_y == L_GY);

   always_comb begin
      w_state_nxt  = r_state;
      w_x_nxt      = r_x;
      w_y_nxt      = r_y;
      w_nx_nxt     = r_nx;
      w_ny_nxt     = r_ny;
      w_move_nxt   = r_move;
      w_steps_nxt  = r_steps;
      w_code_nxt   = r_code;
      w_pend_nxt   = r_pend;
      o_move_ready = 1'b0;
      o_mem_rd     = 1'b0;
      o_mem_addr   = '0;
      case (r_state)
         S_IDLE, S_OK, S_ERR: begin
            if (i_start) begin
               w_state_nxt = S_WAIT;
               w_x_nxt     = '0;
               w_y_nxt     = '0;
               w_steps_nxt = '0;
               w_code_nxt  = 2'b00;
               w_pend_nxt  = 1'b0;
            end
         end
         S_WAIT: begin
            o_move_ready = 1'b1;
            if (i_move_valid) begin
               w_move_nxt  = i_move;
               w_steps_nxt = r_steps + 9'd1;
               if (i_path_done) w_pend_nxt = 1'b1;
               if (r_steps == L_MAX) begin
                  w_state_nxt = S_ERR;
                  w_code_nxt  = 2'b11;
               end else begin
                  w_state_nxt = S_CHECK;
               end
            end else if (r_pend || i_path_done) begin
               w_state_nxt = w_goal ? S_OK : S_ERR;
               if (!w_goal) w_code_nxt = 2'b11;
            end
         end
         S_CHECK: begin
            if (i_path_done) w_pend_nxt = 1'b1;
            if (w_cx[N] || w_cy[N]) begin
               w_state_nxt = S_ERR;
               w_code_nxt  = 2'b01;
            end else begin
               w_state_nxt = S_READ;
               w_nx_nxt    = w_cx[N-1:0];
               w_ny_nxt    = w_cy[N-1:0];
            end
         end
         S_READ: begin
            if (i_path_done) w_pend_nxt = 1'b1;
            o_mem_rd    = 1'b1;
            o_mem_addr  = {r_ny, r_nx};
            w_state_nxt = S_EVAL;
         end
         S_EVAL: begin
            if (i_path_done) w_pend_nxt = 1'b1;
            o_mem_addr = {r_ny, r_nx};
            if (i_mem_dout) begin
               w_state_nxt = S_ERR;
               w_code_nxt  = 2'b10;
            end else begin
               w_state_nxt = S_WAIT;
               w_x_nxt     = r_nx;
               w_y_nxt     = r_ny;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_nx    <= '0;
         r_ny    <= '0;
         r_move  <= 2'b00;
         r_steps <= '0;
         r_code  <= 2'b00;
         r_pend  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_x     <= w_x_nxt;
         r_y     <= w_y_nxt;
         r_nx    <= w_nx_nxt;
         r_ny    <= w_ny_nxt;
         r_move  <= w_move_nxt;
         r_steps <= w_steps_nxt;
         r_code  <= w_code_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

   assign o_x        = r_x;
   assign o_y        = r_y;
   assign o_steps    = r_steps;
   assign o_err_code = r_code;
   assign o_busy     = (r_state == S_WAIT) || (r_state == S_CHECK) ||
                       (r_state == S_READ) || (r_state == S_EVAL);
   assign o_ok       = (r_state == S_OK);
   assign o_err      = (r_state == S_ERR);

endmodule
